lite_nasti_reader: RTL and testbench
====================================

Name: lite_nasti_reader

Overview:
Bridges a NASTI-Lite read initiator onto a full NASTI read port. Each single-word lite read becomes one INCR burst of narrow NASTI beats. The returned beats are reassembled into one lite data word. Sits beside lite_nasti_writer in the lite-to-NASTI bridge; up to MAX_TRANSACTION reads with distinct IDs may be outstanding, and R beats of different IDs may interleave.

Parameters:
MAX_TRANSACTION, 2, number of outstanding-read slots (power of 2, >=2)
ID_WIDTH, 1, AR/R id width
ADDR_WIDTH, 8, address width
NASTI_DATA_WIDTH, 8, NASTI R data width
LITE_DATA_WIDTH, 32, lite R data width; only 32 or 64 legal (elaboration $fatal otherwise)
USER_WIDTH, 1, user field width (>0)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
lite_ar_id/addr/prot/qos/region/user  in  ID_WIDTH/ADDR_WIDTH/3/4/4/USER_WIDTH  lite read address
lite_ar_valid  in  1 ; lite_ar_ready  out  1
lite_r_id/data/resp/user  out  ID_WIDTH/LITE_DATA_WIDTH/2/USER_WIDTH  lite read data
lite_r_valid  out  1 ; lite_r_ready  in  1
nasti_ar_id/addr/len/size/burst/lock/cache/prot/qos/region/user  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/USER_WIDTH  NASTI read address
nasti_ar_valid  out  1 ; nasti_ar_ready  in  1
nasti_r_id/data/resp/last/user  in  ID_WIDTH/NASTI_DATA_WIDTH/2/1/USER_WIDTH  NASTI read data
nasti_r_valid  in  1 ; nasti_r_ready  out  1

Behaviour:
- BUF = min(NASTI_DATA_WIDTH, LITE_DATA_WIDTH); BEATS = LITE_DATA_WIDTH/BUF.
- AR fields: len=BEATS-1; size=log2(BUF/8); burst=2'b01; lock=0; cache=4'b0001; id/addr/prot/qos/region/user pass through.
- Slot states: FREE, PEND (AR issued, collecting beats), DONE (word complete, awaiting lite R). Each slot holds id, beat counter (0..BEATS-1), BEATS x BUF data regs, merged resp, user.
- avail = any slot FREE. conflict = lite_ar_id equals id of any non-FREE slot. Both are computed from registered state only; a slot freed this cycle is not reusable until the next cycle.
- nasti_ar_valid = lite_ar_valid & avail & !conflict. lite_ar_ready = avail & !conflict & nasti_ar_ready.
- On AR handshake: the lowest-index FREE slot goes to PEND with counter=0, resp=0, and records the id.
- nasti_r_ready = nasti_r_id matches a PEND slot. Beats with an unmatched id are never accepted (protocol violation; stall).
- On an R handshake into slot s: data goes to buf[counter]. If the slot was just allocated, counter=0 and resp=nasti_r_resp; otherwise resp=max(resp, nasti_r_resp), numeric, so DECERR>SLVERR>EXOKAY>OKAY. user=nasti_r_user. counter increments.
- On r_last the slot goes to DONE.
- When NASTI_DATA_WIDTH>LITE_DATA_WIDTH, the stored beat is nasti_r_data[LITE_DATA_WIDTH-1:0].
- lite_r_valid = any slot DONE. The output selects the lowest-index DONE slot; lite_r_data = concatenated buf, beat 0 in the LSBs.
- Outputs are held stable until lite_r_ready. On lite R handshake the selected slot goes to FREE.
- Simultaneous events in one cycle are all legal and independent, provided they touch different slots: AR allocation, R beat into one slot, lite R release of another slot.
- Minimum latency: the last R beat at cycle n gives lite_r_valid at cycle n+1. Data is never combinationally forwarded.
- Reset (any time, including mid-burst):
  - all slots FREE, all partial data discarded;
  - lite_r_valid=0, nasti_r_ready=0;
  - nasti_ar_valid=0 unless lite_ar_valid (combinational);
  - data buffers are not reset.

Optional Feature:
- Macro LITE_NASTI_READER_LEN_CHECK_EN.
- Defined: a beat with r_last=1 while counter!=BEATS-1 forces merged resp to 2'b10 (SLVERR). A beat with counter==BEATS-1 and r_last=0 also forces SLVERR, and the slot stays PEND until r_last. Extra beats are accepted but their data is discarded.
- Undefined: r_last alone completes the slot, with no length check. Missing beats leave stale buffer contents.

Test Plan:
- Defaults; lite AR id=0 addr=0x40 -> nasti AR len=3 size=0 burst=1 cache=1. R beats 0x11,0x22,0x33,0x44 (last on 4th), resp OKAY -> lite_r_data=0x44332211, resp=0, one cycle after the last beat.
- Two ARs id=0, id=1; R beats interleaved 0/1/0/1... -> two lite R words, each with correct bytes. Slot 0 is presented first when both are DONE.
- AR id=1 while id=1 is outstanding -> nasti_ar_valid=0 and lite_ar_ready=0 until lite R for id=1 handshakes, then the AR issues the following cycle.
- Beat resps OKAY,SLVERR,OKAY,DECERR -> lite_r_resp=2'b11. Hold lite_r_ready=0 for 5 cycles -> data/id/resp stable.
- Assert rstn low after 2 of 4 beats -> lite_r_valid=0, slot free. A new AR is accepted immediately after reset release.
- With LITE_NASTI_READER_LEN_CHECK_EN, r_last on beat 2 of 4 -> lite_r_resp=2'b10. Without the macro -> resp=OKAY.

Source files
------------

// File: rtl/lite_nasti_reader.sv
// Lite-to-NASTI read bridge: one lite read becomes one INCR burst of narrow beats.
// Define LITE_NASTI_READER_LEN_CHECK_EN to flag bursts whose r_last disagrees with len.
module lite_nasti_reader #(
  parameter int MAX_TRANSACTION  = 2,
  parameter int ID_WIDTH         = 1,
  parameter int ADDR_WIDTH       = 8,
  parameter int NASTI_DATA_WIDTH = 8,
  parameter int LITE_DATA_WIDTH  = 32,
  parameter int USER_WIDTH       = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [ID_WIDTH-1:0]         lite_ar_id,
  input  logic [ADDR_WIDTH-1:0]       lite_ar_addr,
  input  logic [2:0]                  lite_ar_prot,
  input  logic [3:0]                  lite_ar_qos,
  input  logic [3:0]                  lite_ar_region,
  input  logic [USER_WIDTH-1:0]       lite_ar_user,
  input  logic                        lite_ar_valid,
  output logic                        lite_ar_ready,
  output logic [ID_WIDTH-1:0]         lite_r_id,
  output logic [LITE_DATA_WIDTH-1:0]  lite_r_data,
  output logic [1:0]                  lite_r_resp,
  output logic [USER_WIDTH-1:0]       lite_r_user,
  output logic                        lite_r_valid,
  input  logic                        lite_r_ready,
  output logic [ID_WIDTH-1:0]         nasti_ar_id,
  output logic [ADDR_WIDTH-1:0]       nasti_ar_addr,
  output logic [7:0]                  nasti_ar_len,
  output logic [2:0]                  nasti_ar_size,
  output logic [1:0]                  nasti_ar_burst,
  output logic                        nasti_ar_lock,
  output logic [3:0]                  nasti_ar_cache,
  output logic [2:0]                  nasti_ar_prot,
  output logic [3:0]                  nasti_ar_qos,
  output logic [3:0]                  nasti_ar_region,
  output logic [USER_WIDTH-1:0]       nasti_ar_user,
  output logic                        nasti_ar_valid,
  input  logic                        nasti_ar_ready,
  input  logic [ID_WIDTH-1:0]         nasti_r_id,
  input  logic [NASTI_DATA_WIDTH-1:0] nasti_r_data,
  input  logic [1:0]                  nasti_r_resp,
  input  logic                        nasti_r_last,
  input  logic [USER_WIDTH-1:0]       nasti_r_user,
  input  logic                        nasti_r_valid,
  output logic                        nasti_r_ready
);

  localparam int BUF = (NASTI_DATA_WIDTH < LITE_DATA_WIDTH) ?
                       NASTI_DATA_WIDTH : LITE_DATA_WIDTH;
  localparam int BEATS = LITE_DATA_WIDTH / BUF;
  localparam int CW = $clog2(BEATS + 1);
  localparam int SW = $clog2(MAX_TRANSACTION);
  localparam logic [CW-1:0] FULL_CNT = CW'(BEATS);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (LITE_DATA_WIDTH != 32 && LITE_DATA_WIDTH != 64) begin : g_bad_width
    $fatal(1, "lite_nasti_reader: LITE_DATA_WIDTH must be 32 or 64");
  end

  logic [1:0]            state_q [MAX_TRANSACTION];
  logic [ID_WIDTH-1:0]   id_q    [MAX_TRANSACTION];
  logic [CW-1:0]         cnt_q   [MAX_TRANSACTION];
  logic [1:0]            resp_q  [MAX_TRANSACTION];
  logic [USER_WIDTH-1:0] user_q  [MAX_TRANSACTION];
  logic [BUF-1:0]        data_q  [MAX_TRANSACTION][BEATS];

  logic          avail, conflict, r_hit, done_any;
  logic [SW-1:0] a_sel, r_sel, o_sel;
  logic          ar_fire, r_fire, o_fire;
  logic [CW-1:0] cnt_cur;
  logic [1:0]    resp_nxt;

  // Descending scan so the lowest-index match wins each select.
  always_comb begin
    avail    = 1'b0;
    conflict = 1'b0;
    r_hit    = 1'b0;
    done_any = 1'b0;
    a_sel    = '0;
    r_sel    = '0;
    o_sel    = '0;
    for (int s = MAX_TRANSACTION - 1; s >= 0; s--) begin
      if (state_q[s] == S_FREE) begin
        avail = 1'b1;
        a_sel = SW'(s);
      end
      if (state_q[s] != S_FREE && id_q[s] == lite_ar_id)
        conflict = 1'b1;
      if (state_q[s] == S_PEND && id_q[s] == nasti_r_id) begin
        r_hit = 1'b1;
        r_sel = SW'(s);
      end
      if (state_q[s] == S_DONE) begin
        done_any = 1'b1;
        o_sel    = SW'(s);
      end
    end
  end

  assign nasti_ar_valid = lite_ar_valid & avail & ~conflict;
  assign lite_ar_ready  = avail & ~conflict & nasti_ar_ready;
  assign nasti_r_ready  = r_hit;
  assign lite_r_valid   = done_any;

  assign ar_fire = nasti_ar_valid & nasti_ar_ready;
  assign r_fire  = nasti_r_valid & r_hit;
  assign o_fire  = done_any & lite_r_ready;

  always_comb begin
    cnt_cur  = cnt_q[r_sel];
    resp_nxt = resp_q[r_sel];
    if (cnt_cur == '0 || nasti_r_resp > resp_q[r_sel])
      resp_nxt = nasti_r_resp;
`ifdef LITE_NASTI_READER_LEN_CHECK_EN
    if (nasti_r_last ? (cnt_cur != CW'(BEATS - 1))
                     : (cnt_cur == CW'(BEATS - 1)))
      resp_nxt = 2'b10;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < MAX_TRANSACTION; s++) begin
        state_q[s] <= S_FREE;
        id_q[s]    <= '0;
        cnt_q[s]   <= '0;
        resp_q[s]  <= '0;
        user_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < MAX_TRANSACTION; s++) begin
        if (ar_fire && a_sel == SW'(s)) begin
          state_q[s] <= S_PEND;
          id_q[s]    <= lite_ar_id;
          cnt_q[s]   <= '0;
          resp_q[s]  <= '0;
        end
        if (r_fire && r_sel == SW'(s)) begin
          resp_q[s] <= resp_nxt;
          user_q[s] <= nasti_r_user;
          if (cnt_cur != FULL_CNT)
            cnt_q[s] <= cnt_cur + CW'(1);
          if (nasti_r_last)
            state_q[s] <= S_DONE;
        end
        if (o_fire && o_sel == SW'(s))
          state_q[s] <= S_FREE;
      end
    end
  end

  // Beats past the burst length leave the buffer untouched.
  always_ff @(posedge clk) begin
    if (r_fire) begin
      for (int b = 0; b < BEATS; b++)
        if (cnt_cur == CW'(b))
          data_q[r_sel][b] <= nasti_r_data[BUF-1:0];
    end
  end

  always_comb begin
    lite_r_data = '0;
    for (int b = 0; b < BEATS; b++)
      lite_r_data[b*BUF +: BUF] = data_q[o_sel][b];
  end

  assign lite_r_id   = id_q[o_sel];
  assign lite_r_resp = resp_q[o_sel];
  assign lite_r_user = user_q[o_sel];

  assign nasti_ar_id     = lite_ar_id;
  assign nasti_ar_addr   = lite_ar_addr;
  assign nasti_ar_len    = 8'(BEATS - 1);
  assign nasti_ar_size   = 3'($clog2(BUF / 8));
  assign nasti_ar_burst  = 2'b01;
  assign nasti_ar_lock   = 1'b0;
  assign nasti_ar_cache  = 4'b0001;
  assign nasti_ar_prot   = lite_ar_prot;
  assign nasti_ar_qos    = lite_ar_qos;
  assign nasti_ar_region = lite_ar_region;
  assign nasti_ar_user   = lite_ar_user;

endmodule

// File: tb/tb_lite_nasti_reader.sv
// Scoreboard bench for lite_nasti_reader with default parameters.
// Expected lite R words and NASTI ARs are queued by stimulus and checked by a monitor.
module tb_lite_nasti_reader;

`ifdef LITE_NASTI_READER_LEN_CHECK_EN
  localparam logic [1:0] SHORT_RESP = 2'b10;
`else
  localparam logic [1:0] SHORT_RESP = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [0:0]  lite_ar_id = '0;
  logic [7:0]  lite_ar_addr = '0;
  logic [2:0]  lite_ar_prot = 3'b101;
  logic [3:0]  lite_ar_qos = 4'h3;
  logic [3:0]  lite_ar_region = 4'h2;
  logic [0:0]  lite_ar_user = 1'b1;
  logic        lite_ar_valid = 1'b0;
  logic        lite_ar_ready;
  logic [0:0]  lite_r_id;
  logic [31:0] lite_r_data;
  logic [1:0]  lite_r_resp;
  logic [0:0]  lite_r_user;
  logic        lite_r_valid;
  logic        lite_r_ready = 1'b1;
  logic [0:0]  nasti_ar_id;
  logic [7:0]  nasti_ar_addr;
  logic [7:0]  nasti_ar_len;
  logic [2:0]  nasti_ar_size;
  logic [1:0]  nasti_ar_burst;
  logic        nasti_ar_lock;
  logic [3:0]  nasti_ar_cache;
  logic [2:0]  nasti_ar_prot;
  logic [3:0]  nasti_ar_qos;
  logic [3:0]  nasti_ar_region;
  logic [0:0]  nasti_ar_user;
  logic        nasti_ar_valid;
  logic        nasti_ar_ready = 1'b1;
  logic [0:0]  nasti_r_id = '0;
  logic [7:0]  nasti_r_data = '0;
  logic [1:0]  nasti_r_resp = '0;
  logic        nasti_r_last = 1'b0;
  logic [0:0]  nasti_r_user = '0;
  logic        nasti_r_valid = 1'b0;
  logic        nasti_r_ready;

  int total = 0;
  int bad = 0;

  // {id, data, resp, user}
  logic [35:0] exp_r[$];
  // {id, addr}
  logic [8:0]  exp_ar[$];

  always #5 clk = ~clk;

  lite_nasti_reader dut (
    .clk(clk), .rstn(rstn),
    .lite_ar_id(lite_ar_id), .lite_ar_addr(lite_ar_addr),
    .lite_ar_prot(lite_ar_prot), .lite_ar_qos(lite_ar_qos),
    .lite_ar_region(lite_ar_region), .lite_ar_user(lite_ar_user),
    .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
    .lite_r_id(lite_r_id), .lite_r_data(lite_r_data),
    .lite_r_resp(lite_r_resp), .lite_r_user(lite_r_user),
    .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready),
    .nasti_ar_id(nasti_ar_id), .nasti_ar_addr(nasti_ar_addr),
    .nasti_ar_len(nasti_ar_len), .nasti_ar_size(nasti_ar_size),
    .nasti_ar_burst(nasti_ar_burst), .nasti_ar_lock(nasti_ar_lock),
    .nasti_ar_cache(nasti_ar_cache), .nasti_ar_prot(nasti_ar_prot),
    .nasti_ar_qos(nasti_ar_qos), .nasti_ar_region(nasti_ar_region),
    .nasti_ar_user(nasti_ar_user),
    .nasti_ar_valid(nasti_ar_valid), .nasti_ar_ready(nasti_ar_ready),
    .nasti_r_id(nasti_r_id), .nasti_r_data(nasti_r_data),
    .nasti_r_resp(nasti_r_resp), .nasti_r_last(nasti_r_last),
    .nasti_r_user(nasti_r_user),
    .nasti_r_valid(nasti_r_valid), .nasti_r_ready(nasti_r_ready)
  );

  always @(negedge clk) begin
    logic [35:0] e;
    logic [8:0]  a;
    if (rstn && lite_r_valid && lite_r_ready) begin
      total++;
      if (exp_r.size() == 0) begin
        bad++;
        $display("FAIL lite_r_extra: got id=%0h data=%h", lite_r_id, lite_r_data);
      end else begin
        e = exp_r.pop_front();
        if ({lite_r_id, lite_r_data, lite_r_resp, lite_r_user} !== e) begin
          bad++;
          $display("FAIL lite_r_word: got id=%0h data=%h resp=%0d user=%0d, want id=%0h data=%h resp=%0d user=%0d",
                   lite_r_id, lite_r_data, lite_r_resp, lite_r_user,
                   e[35], e[34:3], e[2:1], e[0]);
        end
      end
    end
    if (rstn && nasti_ar_valid && nasti_ar_ready) begin
      total++;
      if (exp_ar.size() == 0) begin
        bad++;
        $display("FAIL nasti_ar_extra: got id=%0h addr=%h", nasti_ar_id, nasti_ar_addr);
      end else begin
        a = exp_ar.pop_front();
        if ({nasti_ar_id, nasti_ar_addr, nasti_ar_len, nasti_ar_size,
             nasti_ar_burst, nasti_ar_lock, nasti_ar_cache, nasti_ar_prot,
             nasti_ar_qos, nasti_ar_region, nasti_ar_user} !==
            {a, 8'd3, 3'd0, 2'b01, 1'b0, 4'b0001, 3'b101, 4'h3, 4'h2, 1'b1}) begin
          bad++;
          $display("FAIL nasti_ar_fields: got id=%0h addr=%h len=%0d size=%0d burst=%0d cache=%0d, want id=%0h addr=%h len=3 size=0 burst=1 cache=1",
                   nasti_ar_id, nasti_ar_addr, nasti_ar_len, nasti_ar_size,
                   nasti_ar_burst, nasti_ar_cache, a[8], a[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input logic [0:0] id, input logic [7:0] addr);
    logic ok;
    exp_ar.push_back({id, addr});
    lite_ar_valid = 1'b1;
    lite_ar_id    = id;
    lite_ar_addr  = addr;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = lite_ar_ready;
      @(posedge clk);
      #1;
    end
    lite_ar_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ar_timeout: got no lite_ar_ready, want ready for id=%0h", id);
    end
  endtask

  task automatic beat(input logic [0:0] id, input logic [7:0] d,
                      input logic [1:0] rs, input logic last, input logic [0:0] u);
    logic ok;
    nasti_r_valid = 1'b1;
    nasti_r_id    = id;
    nasti_r_data  = d;
    nasti_r_resp  = rs;
    nasti_r_last  = last;
    nasti_r_user  = u;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = nasti_r_ready;
      @(posedge clk);
      #1;
    end
    nasti_r_valid = 1'b0;
    nasti_r_last  = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL r_timeout: got no nasti_r_ready, want ready for id=%0h", id);
    end
  endtask

  initial begin
    // reset state, AR valid is combinational even in reset
    #1;
    lite_ar_valid = 1'b1;
    nasti_r_valid = 1'b1;
    #1;
    check("rst_ar_valid", 64'(nasti_ar_valid), 64'd1);
    check("rst_r_valid", 64'(lite_r_valid), 64'd0);
    check("rst_r_ready", 64'(nasti_r_ready), 64'd0);
    lite_ar_valid = 1'b0;
    nasti_r_valid = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
    check("idle_ar_valid", 64'(nasti_ar_valid), 64'd0);
    check("idle_ar_ready", 64'(lite_ar_ready), 64'd1);

    // single read, one-cycle completion latency
    do_ar(1'b0, 8'h40);
    exp_r.push_back({1'b0, 32'h44332211, 2'b00, 1'b1});
    beat(1'b0, 8'h11, 2'b00, 1'b0, 1'b0);
    beat(1'b0, 8'h22, 2'b00, 1'b0, 1'b0);
    beat(1'b0, 8'h33, 2'b00, 1'b0, 1'b0);
    check("lat_before_last", 64'(lite_r_valid), 64'd0);
    beat(1'b0, 8'h44, 2'b00, 1'b1, 1'b1);
    check("lat_after_last", 64'(lite_r_valid), 64'd1);
    idle(3);

    // interleaved ids, slot 0 presented first
    lite_r_ready = 1'b0;
    do_ar(1'b0, 8'h10);
    do_ar(1'b1, 8'h20);
    exp_r.push_back({1'b0, 32'hA3A2A1A0, 2'b00, 1'b0});
    exp_r.push_back({1'b1, 32'hB3B2B1B0, 2'b00, 1'b0});
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 8'hA0 + 8'(i), 2'b00, i == 3, 1'b0);
      beat(1'b1, 8'hB0 + 8'(i), 2'b00, i == 3, 1'b0);
    end
    idle(2);
    check("both_done_id", 64'(lite_r_id), 64'd0);
    lite_r_ready = 1'b1;
    idle(4);

    // id conflict blocks the AR until the outstanding word is released
    lite_r_ready = 1'b0;
    do_ar(1'b1, 8'h30);
    exp_r.push_back({1'b1, 32'h04030201, 2'b00, 1'b0});
    for (int i = 0; i < 4; i++)
      beat(1'b1, 8'h01 + 8'(i), 2'b00, i == 3, 1'b0);
    exp_ar.push_back({1'b1, 8'h31});
    lite_ar_valid = 1'b1;
    lite_ar_id    = 1'b1;
    lite_ar_addr  = 8'h31;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("conflict_block", 64'({nasti_ar_valid, lite_ar_ready}), 64'd0);
    end
    @(posedge clk);
    #1;
    lite_r_ready = 1'b1;
    @(negedge clk);
    check("conflict_release_cycle", 64'(nasti_ar_valid), 64'd0);
    @(posedge clk);
    #1;
    lite_r_ready = 1'b0;
    @(negedge clk);
    check("conflict_ar_issue", 64'({nasti_ar_valid, lite_ar_ready}), 64'd3);
    @(posedge clk);
    #1;
    lite_ar_valid = 1'b0;

    // resp merge and hold stability
    exp_r.push_back({1'b1, 32'h88776655, 2'b11, 1'b0});
    beat(1'b1, 8'h55, 2'b00, 1'b0, 1'b0);
    beat(1'b1, 8'h66, 2'b10, 1'b0, 1'b0);
    beat(1'b1, 8'h77, 2'b00, 1'b0, 1'b0);
    beat(1'b1, 8'h88, 2'b11, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable", 64'({lite_r_valid, lite_r_id, lite_r_data, lite_r_resp}),
            64'({1'b1, 1'b1, 32'h88776655, 2'b11}));
    end
    @(posedge clk);
    #1;
    lite_r_ready = 1'b1;
    idle(3);

    // reset mid-burst
    do_ar(1'b0, 8'h50);
    beat(1'b0, 8'hC1, 2'b00, 1'b0, 1'b0);
    beat(1'b0, 8'hC2, 2'b00, 1'b0, 1'b0);
    rstn = 1'b0;
    nasti_r_valid = 1'b1;
    nasti_r_id = 1'b0;
    #1;
    check("midrst_r_valid", 64'(lite_r_valid), 64'd0);
    check("midrst_r_ready", 64'(nasti_r_ready), 64'd0);
    nasti_r_valid = 1'b0;
    lite_ar_id = 1'b0;
    idle(1);
    check("midrst_slot_free", 64'(lite_ar_ready), 64'd1);
    rstn = 1'b1;
    do_ar(1'b0, 8'h60);
    exp_r.push_back({1'b0, 32'hD4D3D2D1, 2'b00, 1'b0});
    for (int i = 0; i < 4; i++)
      beat(1'b0, 8'hD1 + 8'(i), 2'b00, i == 3, 1'b0);
    idle(3);

    // short burst: early r_last, stale upper bytes
    do_ar(1'b1, 8'h70);
    exp_r.push_back({1'b1, 32'hD4D3E2E1, SHORT_RESP, 1'b0});
    beat(1'b1, 8'hE1, 2'b00, 1'b0, 1'b0);
    beat(1'b1, 8'hE2, 2'b00, 1'b1, 1'b0);

    for (int i = 0; i < 50 && (exp_r.size() != 0 || exp_ar.size() != 0); i++)
      idle(1);
    idle(2);
    check("r_queue_drained", 64'(exp_r.size()), 64'd0);
    check("ar_queue_drained", 64'(exp_ar.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
